updi_uart_tx: RTL and testbench

- Physical-layer transmitter directly downstream of the UPDI instruction queue handler.
- Pops bytes from the instruction byte FIFO (SYNCH 0x55, opcodes, operands) and serialises each as a UPDI UART frame: 8E2, LSB first.
- Drives the UPDI line and a direction enable for the external half-duplex buffer.
- Pulses once per completed frame so upstream logic can track progress.

---
 rtl/updi_uart_tx_if.sv | 19 +
 rtl/updi_uart_tx.sv | 128 ++++++++++++
 tb/tb_updi_uart_tx.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/updi_uart_tx_if.sv
// FIFO read port between the UPDI instruction byte FIFO
// and the UART transmitter that drains it.
interface updi_uart_tx_if;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_rd_en;

  modport master (
    input  fifo_data,
    input  fifo_empty,
    output fifo_rd_en
  );

  modport slave (
    output fifo_data,
    output fifo_empty,
    input  fifo_rd_en
  );
endinterface

// File: rtl/updi_uart_tx.sv
// UPDI UART transmitter: pops FIFO bytes and sends 8E2
// frames LSB first, owning the half-duplex line meanwhile.
module updi_uart_tx #(
  parameter int DIV_BITS  = 16,
  parameter int STOP_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [DIV_BITS-1:0] baud_div,
  updi_uart_tx_if.master      fifo,
  output logic                tx,
  output logic                tx_en,
  output logic                busy,
  output logic                byte_done
);

  localparam int FRAME_LEN = 10 + STOP_BITS;
  localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT
  } state_t;

  state_t state, state_nx;

  logic [11:0]         frame_q;
  logic [DIV_BITS-1:0] div_q;
  logic [DIV_BITS-1:0] baud_cnt;
  logic [3:0]          bit_cnt;

  logic bit_end;
  logic last_bit;
  logic frame_end;
  logic start_ok;

  assign bit_end   = (baud_cnt == div_q);
  assign last_bit  = (bit_cnt == LAST_BIT);
  assign frame_end = (state == SHIFT) && bit_end && last_bit;
  assign start_ok  = en && !fifo.fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start_ok) state_nx = FETCH;
      FETCH: state_nx = LOAD;
      LOAD:  state_nx = SHIFT;
      SHIFT: begin
        if (frame_end) begin
          state_nx = start_ok ? FETCH : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    tx         = 1'b1;
    tx_en      = 1'b0;
    busy       = 1'b0;
    byte_done  = 1'b0;
    fifo.fifo_rd_en = 1'b0;
    unique case (state)
      IDLE: ;
      FETCH: begin
        tx_en           = 1'b1;
        busy            = 1'b1;
        fifo.fifo_rd_en = 1'b1;
      end
      LOAD: begin
        tx_en = 1'b1;
        busy  = 1'b1;
      end
      SHIFT: begin
        tx        = frame_q[0];
        tx_en     = 1'b1;
        busy      = 1'b1;
        byte_done = frame_end;
      end
      default: ;
    endcase
  end

  // Frame is shifted out of bit 0; ones fill in as stop bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_q  <= '1;
      div_q    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          frame_q  <= {2'b11, ^fifo.fifo_data,
                       fifo.fifo_data, 1'b0};
          div_q    <= baud_div;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
        SHIFT: begin
          if (bit_end) begin
            frame_q  <= {1'b1, frame_q[11:1]};
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_updi_uart_tx.sv
// Directed bench for updi_uart_tx with a small FIFO model
// and hand-computed frame bit patterns.
module tb_updi_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] baud_div;
  logic        tx;
  logic        tx_en;
  logic        busy;
  logic        byte_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [16];
  int         wr = 0;
  int         rd = 0;
  int         pops = 0;
  int         dones = 0;
  logic [7:0] fdata = 8'h00;

  updi_uart_tx_if bus ();

  assign bus.fifo_empty = (rd == wr);
  assign bus.fifo_data  = fdata;

  updi_uart_tx #(.DIV_BITS(16), .STOP_BITS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .baud_div  (baud_div),
    .fifo      (bus.master),
    .tx        (tx),
    .tx_en     (tx_en),
    .busy      (busy),
    .byte_done (byte_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      fdata <= mem[rd[3:0]];
      rd    <= rd + 1;
      pops  <= pops + 1;
    end
    if (byte_done) dones <= dones + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h",
             tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr[3:0]] = d;
    wr++;
  endtask

  task automatic wait_start(output int n,
                            output logic en_all);
    n = 0;
    en_all = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (tx_en !== 1'b1) en_all = 1'b0;
    end while (tx !== 1'b0 && n < 40);
  endtask

  // Entered on the first sampled cycle of the start bit.
  task automatic frame(input string tag,
                       input logic [11:0] exp,
                       input int cpb);
    logic ok;
    for (int i = 0; i < 12; i++) begin
      ok = 1'b1;
      for (int c = 0; c < cpb; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        if (tx !== exp[i]) ok = 1'b0;
        if (tx_en !== 1'b1) ok = 1'b0;
        if (byte_done !== (i == 11 && c == cpb - 1))
          ok = 1'b0;
      end
      chk($sformatf("%s bit%0d", tag, i), 32'(ok), 1);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, " tx_en"}, 32'(tx_en), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " tx"}, 32'(tx), 1);
  endtask

  initial begin
    int   n;
    logic ea;
    int   p0;
    int   d0;

    rst      = 1'b0;
    en       = 1'b0;
    baud_div = 16'd3;
    repeat (3) @(negedge clk);
    idle_chk("reset");
    chk("reset rd_en", 32'(bus.fifo_rd_en), 0);
    chk("reset done", 32'(byte_done), 0);
    rst = 1'b1;
    en  = 1'b1;
    repeat (2) @(negedge clk);

    p0 = pops; d0 = dones;
    push(8'h55);
    wait_start(n, ea);
    chk("t1 latency", 32'(n), 3);
    chk("t1 pops", 32'(pops - p0), 1);
    frame("t1", 12'hCAA, 4);
    @(negedge clk);
    idle_chk("t1 end");
    chk("t1 dones", 32'(dones - d0), 1);

    baud_div = 16'd0;
    push(8'h07);
    wait_start(n, ea);
    chk("t2 latency", 32'(n), 3);
    frame("t2", 12'hE0E, 1);
    @(negedge clk);
    idle_chk("t2 end");

    baud_div = 16'd1;
    p0 = pops; d0 = dones;
    push(8'h55);
    push(8'hE5);
    wait_start(n, ea);
    frame("t3a", 12'hCAA, 2);
    wait_start(n, ea);
    chk("t3 gap", 32'(n), 3);
    chk("t3 gap tx_en", 32'(ea), 1);
    frame("t3b", 12'hFCA, 2);
    @(negedge clk);
    idle_chk("t3 end");
    chk("t3 pops", 32'(pops - p0), 2);
    chk("t3 dones", 32'(dones - d0), 2);

    p0 = pops;
    push(8'h12);
    push(8'h34);
    wait_start(n, ea);
    en = 1'b0;
    frame("t4a", 12'hC24, 2);
    repeat (10) @(negedge clk);
    idle_chk("t4 gated");
    chk("t4 gated pops", 32'(pops - p0), 1);
    en = 1'b1;
    wait_start(n, ea);
    chk("t4 latency", 32'(n), 3);
    frame("t4b", 12'hE68, 2);
    @(negedge clk);
    idle_chk("t4 end");

    baud_div = 16'd3;
    d0 = dones;
    push(8'h55);
    wait_start(n, ea);
    repeat (16) @(negedge clk);
    chk("t5 d3 tx", 32'(tx), 0);
    chk("t5 d3 busy", 32'(busy), 1);
    rst = 1'b0;
    @(negedge clk);
    idle_chk("t5 rst");
    chk("t5 rst done", 32'(byte_done), 0);
    @(negedge clk);
    rst = 1'b1;
    p0 = pops;
    repeat (8) @(negedge clk);
    chk("t5 no pop", 32'(pops - p0), 0);
    chk("t5 no done", 32'(dones - d0), 0);
    idle_chk("t5 idle");
    push(8'hAA);
    wait_start(n, ea);
    chk("t5 latency", 32'(n), 3);
    frame("t5", 12'hD54, 4);
    @(negedge clk);
    chk("t5 dones", 32'(dones - d0), 1);

    baud_div = 16'd3;
    push(8'h55);
    push(8'h07);
    wait_start(n, ea);
    baud_div = 16'd7;
    frame("t6a", 12'hCAA, 4);
    wait_start(n, ea);
    chk("t6 gap", 32'(n), 3);
    frame("t6b", 12'hE0E, 8);
    @(negedge clk);
    idle_chk("t6 end");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
